// File: rtl/memwb_skid_reg_pkg.sv
// memwb_pkg: shared constants and lane bundle type for the MEM->WB register.
// No ports; imported by the interface, sanitizer and top.
package memwb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int DEF_LANES  = 2;
  localparam int DEF_SIDE_W = 120;

  typedef struct packed {
    logic                  lane_valid;
    logic                  wreg;
    logic [REG_ADDR_W-1:0] wa;
    logic [WORD_W-1:0]     wdata;
    logic [DEF_SIDE_W-1:0] side;
  } memwb_lane_t;

  function automatic int lane_bits(input int side_w);
    return 2 + REG_ADDR_W + WORD_W + side_w;
  endfunction

endpackage

// File: rtl/memwb_skid_reg_if.sv
// memwb_skid_reg_if: MEM-side offer channel and WB-side bundle channel.
// master = MEM/WB environment, slave = the pipeline register.
interface memwb_skid_reg_if
  import memwb_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int SIDE_W = DEF_SIDE_W
);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0]            in_lane_valid;
  logic [LANES-1:0]            in_excp;
  logic [LANES-1:0]            in_wreg;
  logic [LANES*REG_ADDR_W-1:0] in_wa;
  logic [LANES*WORD_W-1:0]     in_wdata;
  logic [LANES*SIDE_W-1:0]     in_side;

  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0]            out_lane_valid;
  logic [LANES-1:0]            out_wreg;
  logic [LANES*REG_ADDR_W-1:0] out_wa;
  logic [LANES*WORD_W-1:0]     out_wdata;
  logic [LANES*SIDE_W-1:0]     out_side;

  modport master (
    output in_valid, in_lane_valid, in_excp,
    output in_wreg, in_wa, in_wdata, in_side,
    output out_ready,
    input  in_ready,
    input  out_valid, out_lane_valid, out_wreg,
    input  out_wa, out_wdata, out_side
  );

  modport slave (
    input  in_valid, in_lane_valid, in_excp,
    input  in_wreg, in_wa, in_wdata, in_side,
    input  out_ready,
    output in_ready,
    output out_valid, out_lane_valid, out_wreg,
    output out_wa, out_wdata, out_side
  );

endinterface

// File: rtl/memwb_lane_sanitize.sv
// memwb_lane_sanitize: in-order exception kill, invalid-lane zeroing and
// same-destination collision clear. Ports: raw *_i lanes in, clean *_o out.
module memwb_lane_sanitize
  import memwb_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int SIDE_W = DEF_SIDE_W
) (
  input  logic [LANES-1:0]            lane_valid_i,
  input  logic [LANES-1:0]            excp_i,
  input  logic [LANES-1:0]            wreg_i,
  input  logic [LANES*REG_ADDR_W-1:0] wa_i,
  input  logic [LANES*WORD_W-1:0]     wdata_i,
  input  logic [LANES*SIDE_W-1:0]     side_i,
  output logic [LANES-1:0]            lane_valid_o,
  output logic [LANES-1:0]            wreg_o,
  output logic [LANES*REG_ADDR_W-1:0] wa_o,
  output logic [LANES*WORD_W-1:0]     wdata_o,
  output logic [LANES*SIDE_W-1:0]     side_o
);

  logic             kill;
  logic [LANES-1:0] lv;
  logic [LANES-1:0] wr;

  always_comb begin
    kill    = 1'b0;
    lv      = '0;
    wr      = '0;
    wa_o    = '0;
    wdata_o = '0;
    side_o  = '0;
    for (int i = 0; i < LANES; i++) begin
      lv[i] = lane_valid_i[i] & ~kill;
      wr[i] = wreg_i[i] & lv[i] & ~excp_i[i];
      // an excepting lane kills everything younger
      kill  = kill | (lv[i] & excp_i[i]);
      if (lv[i]) begin
        wa_o[i*REG_ADDR_W +: REG_ADDR_W] =
          wa_i[i*REG_ADDR_W +: REG_ADDR_W];
        wdata_o[i*WORD_W +: WORD_W] =
          wdata_i[i*WORD_W +: WORD_W];
        side_o[i*SIDE_W +: SIDE_W] =
          side_i[i*SIDE_W +: SIDE_W];
      end
    end
  end

  // younger lane wins a same-destination write
  always_comb begin
    lane_valid_o = lv;
    wreg_o       = wr;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (wr[i] && wr[j] &&
            wa_i[i*REG_ADDR_W +: REG_ADDR_W] ==
            wa_i[j*REG_ADDR_W +: REG_ADDR_W])
          wreg_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/memwb_skid_reg.sv
// memwb_skid_reg: MEM->WB register with one-entry skid buffer and flush.
// Ports: clk, resetn (sync, low), flush, bus (slave: MEM offer / WB bundle).
module memwb_skid_reg
  import memwb_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int SIDE_W = DEF_SIDE_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  memwb_skid_reg_if.slave   bus
);

  localparam int BW = LANES * lane_bits(SIDE_W);

  // bit0 = MAIN valid, bit1 = SKID valid
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;
  logic          rdy_q, rdy_d;
  logic [BW-1:0] san;
  logic          acc, drn;

  logic [LANES-1:0]            s_lv, s_wr;
  logic [LANES*REG_ADDR_W-1:0] s_wa;
  logic [LANES*WORD_W-1:0]     s_wd;
  logic [LANES*SIDE_W-1:0]     s_sd;

  memwb_lane_sanitize #(
    .LANES  (LANES),
    .SIDE_W (SIDE_W)
  ) u_san (
    .lane_valid_i (bus.in_lane_valid),
    .excp_i       (bus.in_excp),
    .wreg_i       (bus.in_wreg),
    .wa_i         (bus.in_wa),
    .wdata_i      (bus.in_wdata),
    .side_i       (bus.in_side),
    .lane_valid_o (s_lv),
    .wreg_o       (s_wr),
    .wa_o         (s_wa),
    .wdata_o      (s_wd),
    .side_o       (s_sd)
  );

  assign san = {s_lv, s_wr, s_wa, s_wd, s_sd};

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = state_q[0];
  assign {bus.out_lane_valid, bus.out_wreg, bus.out_wa,
          bus.out_wdata, bus.out_side} = main_q;

  assign acc = bus.in_valid & rdy_q;
  assign drn = state_q[0] & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_BUSY;
            main_d  = san;
          end
        end
        ST_BUSY: begin
          if (acc && drn) begin
            main_d = san;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = san;
          end else if (drn) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (drn) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    rdy_d = ~state_d[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_memwb_skid_reg.sv
// tb_memwb_skid_reg: directed checks of streaming, stall, kill, collision,
// flush and reset on a 2-lane and a 4-lane instance.
module tb_memwb_skid_reg;
  import memwb_pkg::*;

  logic clk = 1'b0;
  logic rstn_a, rstn_b, flush_a, flush_b;

  always #5 clk = ~clk;

  memwb_skid_reg_if #(.LANES(2), .SIDE_W(120)) ba ();
  memwb_skid_reg_if #(.LANES(4), .SIDE_W(8))   bb ();

  memwb_skid_reg #(.LANES(2), .SIDE_W(120)) dut_a (
    .clk    (clk),
    .resetn (rstn_a),
    .flush  (flush_a),
    .bus    (ba.slave)
  );

  memwb_skid_reg #(.LANES(4), .SIDE_W(8)) dut_b (
    .clk    (clk),
    .resetn (rstn_b),
    .flush  (flush_b),
    .bus    (bb.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [239:0] side_a(
    input logic [1:0] lv, input logic [31:0] d0, d1);
    logic [119:0] s0, s1;
    s0 = lv[0] ? {8'hC0, 80'h0, d0} : 120'h0;
    s1 = lv[1] ? {8'hC1, 80'h0, d1} : 120'h0;
    return {s1, s0};
  endfunction

  task automatic offer_a(input logic v, input logic [1:0] lv, ex, wr,
                         input logic [4:0] wa0, wa1,
                         input logic [31:0] d0, d1);
    ba.in_valid      = v;
    ba.in_lane_valid = lv;
    ba.in_excp       = ex;
    ba.in_wreg       = wr;
    ba.in_wa         = {wa1, wa0};
    ba.in_wdata      = {d1, d0};
    ba.in_side       = side_a(2'b11, d0, d1);
  endtask

  task automatic idle_a();
    offer_a(1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic see_a(input string t, input logic v,
                       input logic [1:0] lv, wr,
                       input logic [4:0] wa0, wa1,
                       input logic [31:0] d0, d1);
    chk({t, ".valid"}, ba.out_valid, v);
    chk({t, ".lv"},    ba.out_lane_valid, lv);
    chk({t, ".wreg"},  ba.out_wreg, wr);
    chk({t, ".wa"},    ba.out_wa, {wa1, wa0});
    chk({t, ".wdata"}, ba.out_wdata, {d1, d0});
    chk({t, ".side"},  ba.out_side, side_a(lv, d0, d1));
  endtask

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    ba.out_ready = 1'b0;
    bb.out_ready = 1'b0;
    bb.in_valid = 1'b0;
    bb.in_lane_valid = '0;
    bb.in_excp = '0;
    bb.in_wreg = '0;
    bb.in_wa = '0;
    bb.in_wdata = '0;
    bb.in_side = '0;
    // offers during reset are dropped
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF);
    repeat (2) @(negedge clk);
    chk("rst.ready", ba.in_ready, 1'b1);
    see_a("rst", 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rstn_a = 1'b1;
    idle_a();
    @(negedge clk);
    chk("rst.after", ba.out_valid, 1'b0);

    // streaming
    ba.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd3, 5'd4,
              32'h11 + (k << 8), 32'h22 + (k << 8));
      chk("str.ready", ba.in_ready, 1'b1);
      @(negedge clk);
      see_a("str", 1'b1, 2'b11, 2'b11, 5'd3, 5'd4,
            32'h11 + (k << 8), 32'h22 + (k << 8));
    end
    idle_a();
    @(negedge clk);
    see_a("str.bub", 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // back-pressure: A held, B in skid, C waits
    ba.out_ready = 1'b0;
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hA0, 32'hA1);
    @(negedge clk);
    see_a("bp.a1", 1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hA0, 32'hA1);
    chk("bp.rdy1", ba.in_ready, 1'b1);
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hB0, 32'hB1);
    @(negedge clk);
    see_a("bp.a2", 1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hA0, 32'hA1);
    chk("bp.rdy2", ba.in_ready, 1'b0);
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hC0, 32'hC1);
    @(negedge clk);
    see_a("bp.a3", 1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hA0, 32'hA1);
    chk("bp.rdy3", ba.in_ready, 1'b0);
    ba.out_ready = 1'b1;
    @(negedge clk);
    see_a("bp.b", 1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hB0, 32'hB1);
    chk("bp.rdy4", ba.in_ready, 1'b1);
    @(negedge clk);
    see_a("bp.c", 1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hC0, 32'hC1);
    idle_a();
    @(negedge clk);
    see_a("bp.bub", 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // exception kill and collision
    offer_a(1'b1, 2'b11, 2'b01, 2'b11, 5'd5, 5'd6, 32'h55, 32'h66);
    @(negedge clk);
    see_a("ex01", 1'b1, 2'b01, 2'b00, 5'd5, 5'd0, 32'h55, 32'h0);
    offer_a(1'b1, 2'b11, 2'b10, 2'b11, 5'd5, 5'd6, 32'h55, 32'h66);
    @(negedge clk);
    see_a("ex10", 1'b1, 2'b11, 2'b01, 5'd5, 5'd6, 32'h55, 32'h66);
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB);
    @(negedge clk);
    see_a("coll", 1'b1, 2'b11, 2'b10, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB);
    offer_a(1'b1, 2'b10, 2'b00, 2'b11, 5'd8, 5'd9, 32'h88, 32'h99);
    @(negedge clk);
    see_a("inv0", 1'b1, 2'b10, 2'b10, 5'd0, 5'd9, 32'h0, 32'h99);
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd0, 5'd12, 32'h1, 32'h2);
    @(negedge clk);
    see_a("wa0", 1'b1, 2'b11, 2'b11, 5'd0, 5'd12, 32'h1, 32'h2);
    idle_a();
    @(negedge clk);

    // flush while FULL, with an offer in the flush cycle
    ba.out_ready = 1'b0;
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hD0, 32'hD1);
    @(negedge clk);
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hE0, 32'hE1);
    @(negedge clk);
    see_a("fl.d", 1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hD0, 32'hD1);
    chk("fl.full", ba.in_ready, 1'b0);
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd2, 32'hF0, 32'hF1);
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    idle_a();
    see_a("fl.0", 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("fl.rdy", ba.in_ready, 1'b1);
    ba.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      see_a("fl.gone", 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    end
    offer_a(1'b1, 2'b11, 2'b00, 2'b11, 5'd3, 5'd4, 32'h60, 32'h61);
    @(negedge clk);
    see_a("fl.g", 1'b1, 2'b11, 2'b11, 5'd3, 5'd4, 32'h60, 32'h61);
    idle_a();
    @(negedge clk);

    // 4-lane instance: fill, reset mid-stall, resume
    rstn_b = 1'b1;
    bb.in_valid = 1'b1;
    bb.in_lane_valid = 4'b1111;
    bb.in_wreg = 4'b1111;
    bb.in_wa = {5'd4, 5'd3, 5'd2, 5'd1};
    bb.in_wdata = {32'h5, 32'h6, 32'h7, 32'h8};
    bb.in_side = 32'h55667788;
    @(negedge clk);
    bb.in_wdata = {32'h9, 32'hA, 32'hB, 32'hC};
    @(negedge clk);
    chk("b.full", bb.in_ready, 1'b0);
    chk("b.held", bb.out_wdata, {32'h5, 32'h6, 32'h7, 32'h8});
    rstn_b = 1'b0;
    @(negedge clk);
    rstn_b = 1'b1;
    bb.in_valid = 1'b0;
    chk("b.rst.v", bb.out_valid, 1'b0);
    chk("b.rst.lv", bb.out_lane_valid, 4'b0);
    chk("b.rst.wd", bb.out_wdata, 128'h0);
    chk("b.rst.sd", bb.out_side, 32'h0);
    chk("b.rst.rdy", bb.in_ready, 1'b1);
    bb.out_ready = 1'b1;
    bb.in_valid = 1'b1;
    bb.in_lane_valid = 4'b1111;
    bb.in_excp = 4'b0100;
    bb.in_wreg = 4'b1111;
    bb.in_wa = {5'd10, 5'd9, 5'd2, 5'd2};
    bb.in_wdata = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    bb.in_side = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    bb.in_valid = 1'b0;
    chk("b.v", bb.out_valid, 1'b1);
    chk("b.lv", bb.out_lane_valid, 4'b0111);
    chk("b.wreg", bb.out_wreg, 4'b0010);
    chk("b.wa", bb.out_wa, {5'd0, 5'd9, 5'd2, 5'd2});
    chk("b.wd", bb.out_wdata, {32'h0, 32'h3333, 32'h2222, 32'h1111});
    chk("b.sd", bb.out_side, {8'h0, 8'h33, 8'h22, 8'h11});
    @(negedge clk);
    chk("b.bub", bb.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
